// File: rtl/movegen_pkg.sv
// ---------------------------------------------------------------------------
// movegen_pkg
//   Shared definitions for the move-generator square array, its sequencer
//   and move consumers: piece codes, colour bit position, square index width
//   and the sequencer state encoding.
//   Piece nibble layout: {colour, piece[2:0]}, colour 1 = white, piece 0 = empty.
// ---------------------------------------------------------------------------
package movegen_pkg;

    localparam logic [2:0] PIECE_KING   = 3'd1;
    localparam logic [2:0] PIECE_QUEEN  = 3'd2;
    localparam logic [2:0] PIECE_ROOK   = 3'd3;
    localparam logic [2:0] PIECE_BISHOP = 3'd4;
    localparam logic [2:0] PIECE_KNIGHT = 3'd5;
    localparam logic [2:0] PIECE_PAWN   = 3'd6;

    localparam int COLOUR_BIT = 3;
    localparam int SQ_W       = 6;

    // Sequencer states
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_SRC    = 3'd2;
    localparam logic [2:0] ST_SETTLE = 3'd3;
    localparam logic [2:0] ST_EMIT   = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    typedef logic [2:0] movegen_state_t;

    // A square is a move source when it holds a piece of the side to move.
    function automatic logic is_own_piece(input logic [3:0] pc, input logic wtp);
        return (|pc[2:0]) && (pc[COLOUR_BIT] == wtp);
    endfunction

endpackage

// File: rtl/lsb_index64.sv
// ---------------------------------------------------------------------------
// lsb_index64
//   Combinational lowest-set-bit finder over a 64-bit square mask.
//   Ports:
//     vec_i  in  64  mask to search
//     idx_o  out 6   index of lowest set bit (0 when vec_i is zero)
//     any_o  out 1   vec_i has at least one bit set
// ---------------------------------------------------------------------------
module lsb_index64
    import movegen_pkg::*;
(
    input  logic [63:0]     vec_i,
    output logic [SQ_W-1:0] idx_o,
    output logic            any_o
);

    always_comb begin
        idx_o = '0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int k = 63; k >= 0; k--) begin
            if (vec_i[k]) begin
                idx_o = SQ_W'(k);
            end
        end
    end

    assign any_o = |vec_i;

endmodule

// File: rtl/movegen_seq.sv
// ---------------------------------------------------------------------------
// movegen_seq
//   Sequencer at the far end of the square array. Captures one board
//   snapshot, shifts it into the square chain (nibble 63 first), then selects
//   each side-to-move piece in ascending square order, waits for the chain to
//   settle, and streams the resulting (from,to) pairs on a valid/ready port.
//   Ports:
//     clk, rst_n                     clock, async active-low reset
//     i_start/i_board/i_wtp/
//       i_castle_rights              run request and position snapshot
//     o_busy, o_done                 run in progress / end-of-run pulse
//     o_pos_valid, o_pos_data        chain shift enable and head nibble
//     o_wtp, o_castle_rights         registered side-to-move and castling
//     o_emit_move, i_target          one-hot source select / target flags
//     o_move_valid, i_move_ready,
//       o_move_from, o_move_to       move stream
//     o_move_count                   moves accepted this run (saturating)
// ---------------------------------------------------------------------------
module movegen_seq
    import movegen_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_start,
    input  logic [255:0]    i_board,
    input  logic            i_wtp,
    input  logic [3:0]      i_castle_rights,
    output logic            o_busy,
    output logic            o_pos_valid,
    output logic [3:0]      o_pos_data,
    output logic            o_wtp,
    output logic [3:0]      o_castle_rights,
    output logic [63:0]     o_emit_move,
    input  logic [63:0]     i_target,
    output logic            o_move_valid,
    input  logic            i_move_ready,
    output logic [SQ_W-1:0] o_move_from,
    output logic [SQ_W-1:0] o_move_to,
    output logic [7:0]      o_move_count,
    output logic            o_done
);

    localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    movegen_state_t  state_q,  state_d;
    logic [255:0]    board_q,  board_d;
    logic            wtp_q,    wtp_d;
    logic [3:0]      castle_q, castle_d;
    logic [63:0]     play_q,   play_d;
    logic [63:0]     tgt_q,    tgt_d;
    logic [63:0]     emit_q,   emit_d;
    logic [5:0]      shift_q,  shift_d;
    logic [SCW-1:0]  settle_q, settle_d;
    logic [SQ_W-1:0] from_q,   from_d;
    logic [7:0]      count_q,  count_d;

    logic [SQ_W-1:0] play_idx, tgt_idx;
    logic            play_any, tgt_any;
    logic [63:0]     start_mask;

    lsb_index64 u_play_lsb (.vec_i(play_q), .idx_o(play_idx), .any_o(play_any));
    lsb_index64 u_tgt_lsb  (.vec_i(tgt_q),  .idx_o(tgt_idx),  .any_o(tgt_any));

    always_comb begin
        start_mask = '0;
        for (int k = 0; k < 64; k++) begin
            start_mask[k] = is_own_piece(i_board[4*k +: 4], i_wtp);
        end
    end

    always_comb begin
        state_d  = state_q;
        board_d  = board_q;
        wtp_d    = wtp_q;
        castle_d = castle_q;
        play_d   = play_q;
        tgt_d    = tgt_q;
        emit_d   = emit_q;
        shift_d  = shift_q;
        settle_d = settle_q;
        from_d   = from_q;
        count_d  = count_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    board_d  = i_board;
                    wtp_d    = i_wtp;
                    castle_d = i_castle_rights;
                    play_d   = start_mask;
                    count_d  = '0;
                    shift_d  = '0;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // Top nibble is the chain head; shifting left walks 63 down to 0.
                board_d = {board_q[251:0], 4'h0};
                shift_d = shift_q + 6'd1;
                if (shift_q == 6'd63) begin
                    state_d = ST_SRC;
                end
            end
            ST_SRC: begin
                if (!play_any) begin
                    state_d = ST_DONE;
                end else begin
                    from_d   = play_idx;
                    emit_d   = 64'd1 << play_idx;
                    play_d   = play_q & ~(64'd1 << play_idx);
                    settle_d = '0;
                    state_d  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_q == SCW'(SETTLE_CYCLES - 1)) begin
                    // A piece never moves onto its own square.
                    tgt_d   = i_target & ~emit_q;
                    emit_d  = '0;
                    state_d = ST_EMIT;
                end else begin
                    settle_d = settle_q + SCW'(1);
                end
            end
            ST_EMIT: begin
                if (!tgt_any) begin
                    state_d = ST_SRC;
                end else if (i_move_ready) begin
                    tgt_d = tgt_q & ~(64'd1 << tgt_idx);
                    if (count_q != 8'hFF) begin
                        count_d = count_q + 8'd1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            board_q  <= '0;
            wtp_q    <= 1'b0;
            castle_q <= '0;
            play_q   <= '0;
            tgt_q    <= '0;
            emit_q   <= '0;
            shift_q  <= '0;
            settle_q <= '0;
            from_q   <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            board_q  <= board_d;
            wtp_q    <= wtp_d;
            castle_q <= castle_d;
            play_q   <= play_d;
            tgt_q    <= tgt_d;
            emit_q   <= emit_d;
            shift_q  <= shift_d;
            settle_q <= settle_d;
            from_q   <= from_d;
            count_q  <= count_d;
        end
    end

    assign o_busy          = (state_q != ST_IDLE);
    assign o_done          = (state_q == ST_DONE);
    assign o_pos_valid     = (state_q == ST_LOAD);
    assign o_pos_data      = board_q[255:252];
    assign o_wtp           = wtp_q;
    assign o_castle_rights = castle_q;
    assign o_emit_move     = emit_q;
    assign o_move_valid    = (state_q == ST_EMIT) && tgt_any;
    assign o_move_from     = from_q;
    assign o_move_to       = tgt_idx;
    assign o_move_count    = count_q;

endmodule

// File: tb/tb_movegen_seq.sv
// ---------------------------------------------------------------------------
// tb_movegen_seq
//   Self-checking bench for movegen_seq. A stub square array answers each
//   emitted source with a per-square target table; expected sources, moves
//   and counts are derived from the board with a simple queue-based model.
// ---------------------------------------------------------------------------
module tb_movegen_seq;

    localparam int SETTLE = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_start;
    logic [255:0]  i_board;
    logic          i_wtp;
    logic [3:0]    i_castle_rights;
    logic          o_busy;
    logic          o_pos_valid;
    logic [3:0]    o_pos_data;
    logic          o_wtp;
    logic [3:0]    o_castle_rights;
    logic [63:0]   o_emit_move;
    logic [63:0]   i_target;
    logic          o_move_valid;
    logic          i_move_ready;
    logic [5:0]    o_move_from;
    logic [5:0]    o_move_to;
    logic [7:0]    o_move_count;
    logic          o_done;

    movegen_seq #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_start(i_start), .i_board(i_board), .i_wtp(i_wtp),
        .i_castle_rights(i_castle_rights),
        .o_busy(o_busy), .o_pos_valid(o_pos_valid), .o_pos_data(o_pos_data),
        .o_wtp(o_wtp), .o_castle_rights(o_castle_rights),
        .o_emit_move(o_emit_move), .i_target(i_target),
        .o_move_valid(o_move_valid), .i_move_ready(i_move_ready),
        .o_move_from(o_move_from), .o_move_to(o_move_to),
        .o_move_count(o_move_count), .o_done(o_done)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    string       cur_case = "init";
    logic [63:0] tgt_tab [64];

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s/%s: got 0x%0h, expected 0x%0h", cur_case, name, obs, exp);
        end
    endtask

    function automatic int idx_of(input logic [63:0] v);
        for (int i = 0; i < 64; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int sat255(input int a);
        return (a > 255) ? 255 : a;
    endfunction

    // colour_mode 0: mixed colours, 1: black only
    function automatic logic [255:0] rand_board(input int colour_mode);
        logic [255:0] b;
        b = '0;
        for (int k = 0; k < 64; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                int p;
                int c;
                p = $urandom_range(1, 6);
                c = (colour_mode == 1) ? 0 : $urandom_range(0, 1);
                b[4*k +: 4] = 4'(c * 8 + p);
            end else if ($urandom_range(0, 15) == 0) begin
                b[4*k +: 4] = 4'h8;   // colour bit set but no piece
            end
        end
        return b;
    endfunction

    task automatic clear_targets();
        for (int s = 0; s < 64; s++) tgt_tab[s] = '0;
    endtask

    task automatic drive_target();
        if (o_emit_move == 64'd0) i_target = {$urandom, $urandom};
        else                      i_target = tgt_tab[idx_of(o_emit_move)];
    endtask

    // rmode 0: ready always high, 1: toggle 1010.., 2: random
    task automatic run_case(input logic [255:0] brd, input logic w, input logic [3:0] cr,
                            input int rmode, output int got_count);
        int src_q[$];
        int mv_q[$];
        int loads, accepted, cycles, hold, exp_cnt, pc, m;
        logic [63:0] prev_emit;
        logic stalled, tog, done_seen;
        logic [5:0] pf, pt;

        for (int s = 0; s < 64; s++) begin
            pc = int'(brd[4*s +: 4]);
            if ((pc % 8) != 0 && (pc / 8) == int'(w)) begin
                src_q.push_back(s);
                for (int t = 0; t < 64; t++)
                    if (tgt_tab[s][t] && t != s) mv_q.push_back(s * 64 + t);
            end
        end
        exp_cnt = sat255(mv_q.size());

        @(negedge clk);
        i_board = brd; i_wtp = w; i_castle_rights = cr; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        chk("busy_after_start", o_busy, 1);
        chk("wtp_latched", o_wtp, w);
        chk("castle_latched", o_castle_rights, cr);

        loads = 0; accepted = 0; cycles = 0; hold = 0;
        prev_emit = '0; stalled = 1'b0; tog = 1'b1; done_seen = 1'b0; pf = '0; pt = '0;
        while (!done_seen && cycles < 5000) begin
            drive_target();
            case (rmode)
                0:       i_move_ready = 1'b1;
                1:       begin i_move_ready = tog; tog = ~tog; end
                default: i_move_ready = 1'($urandom_range(0, 1));
            endcase
            // Noise on the start port must be ignored while busy.
            i_start = ($urandom_range(0, 3) == 0);
            i_board = {8{$urandom}};
            i_wtp = 1'($urandom);
            i_castle_rights = 4'($urandom);

            if (o_pos_valid) begin
                if (loads < 64) chk("pos_data", o_pos_data, brd[4*(63-loads) +: 4]);
                else            chk("load_len", loads, 63);
                chk("load_quiet", (o_emit_move != 0) || o_move_valid, 0);
                loads++;
            end

            if (o_emit_move != prev_emit) begin
                if (prev_emit != 0) chk("emit_hold", hold, SETTLE);
                if (o_emit_move != 0) begin
                    chk("emit_onehot", $onehot(o_emit_move), 1);
                    if (src_q.size() == 0) chk("emit_extra", o_emit_move, 0);
                    else                   chk("emit_src", idx_of(o_emit_move), src_q.pop_front());
                end
                hold = (o_emit_move != 0) ? 1 : 0;
            end else if (o_emit_move != 0) begin
                hold++;
            end
            prev_emit = o_emit_move;

            if (stalled) begin
                chk("stall_valid", o_move_valid, 1);
                chk("stall_move", {o_move_from, o_move_to}, {pf, pt});
            end
            if (o_move_valid) begin
                if (i_move_ready) begin
                    chk("count_live", o_move_count, sat255(accepted));
                    if (mv_q.size() == 0) chk("move_extra", {o_move_from, o_move_to}, 64'hFFFF);
                    else begin
                        m = mv_q.pop_front();
                        chk("move", {o_move_from, o_move_to}, m);
                    end
                    accepted++;
                end
                stalled = ~i_move_ready;
                pf = o_move_from; pt = o_move_to;
            end else begin
                stalled = 1'b0;
            end

            if (o_done) begin
                done_seen = 1'b1;
                chk("final_count", o_move_count, exp_cnt);
                chk("load_cycles", loads, 64);
                chk("sources_left", src_q.size(), 0);
                chk("moves_left", mv_q.size(), 0);
                chk("wtp_held", o_wtp, w);
                i_start = 1'b1;   // start during DONE must be ignored
            end
            @(negedge clk);
            cycles++;
        end
        if (!done_seen) chk("timeout", 0, 1);
        else begin
            chk("start_in_done", o_busy, 0);
            chk("done_pulse", o_done, 0);
        end
        i_start = 1'b0;
        i_move_ready = 1'b0;
        got_count = int'(o_move_count);
    endtask

    initial begin
        int got;
        int n;
        logic [255:0] brd;

        rst_n = 1'b0; i_start = 1'b0; i_board = '0; i_wtp = 1'b0;
        i_castle_rights = '0; i_target = '0; i_move_ready = 1'b0;
        clear_targets();
        repeat (3) @(negedge clk);
        cur_case = "reset";
        chk("busy", o_busy, 0);
        chk("done", o_done, 0);
        chk("pos_valid", o_pos_valid, 0);
        chk("emit", o_emit_move, 0);
        chk("move_valid", o_move_valid, 0);
        chk("count", o_move_count, 0);
        chk("regs", {o_wtp, o_castle_rights, o_move_from, o_move_to, o_pos_data}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        cur_case = "empty";
        run_case('0, 1'b1, 4'hF, 0, got);
        chk("count", got, 0);

        cur_case = "king_e1";
        clear_targets();
        tgt_tab[4] = 64'h0000_0000_0000_3828;
        run_case(256'h9 << 16, 1'b1, 4'h5, 0, got);
        chk("count5", got, 5);

        cur_case = "black_only";
        clear_targets();
        for (int s = 0; s < 64; s++) tgt_tab[s] = {$urandom, $urandom};
        run_case(rand_board(1), 1'b1, 4'h3, 2, got);
        chk("count", got, 0);

        cur_case = "a1_h1_toggle";
        clear_targets();
        tgt_tab[0] = 64'h0101_0101_0101_01FF;   // includes its own square bit 0
        tgt_tab[7] = 64'h8080_8080_8080_80FF;
        brd = '0;
        brd[3:0]   = 4'hB;
        brd[31:28] = 4'hB;
        run_case(brd, 1'b1, 4'h0, 1, got);
        chk("count", got, 28);

        cur_case = "reset_mid";
        clear_targets();
        tgt_tab[4] = 64'h0000_0000_0000_3828;
        @(negedge clk);
        i_board = 256'h9 << 16; i_wtp = 1'b1; i_castle_rights = 4'hA; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        i_move_ready = 1'b1;
        n = 0;
        while (o_move_count != 8'd2 && n < 300) begin
            drive_target();
            @(negedge clk);
            n++;
        end
        chk("reached_emit", o_move_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("busy", o_busy, 0);
        chk("move_valid", o_move_valid, 0);
        chk("count", o_move_count, 0);
        chk("regs", {o_wtp, o_castle_rights, o_move_from, o_move_to}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        i_move_ready = 1'b0;
        run_case(256'h9 << 16, 1'b1, 4'h6, 2, got);
        chk("fresh_count", got, 5);

        for (int r = 0; r < 5; r++) begin
            cur_case = $sformatf("random%0d", r);
            for (int s = 0; s < 64; s++) tgt_tab[s] = {$urandom, $urandom} & {$urandom, $urandom};
            run_case(rand_board(0), 1'($urandom), 4'($urandom), r % 3, got);
        end

        cur_case = "saturate";
        for (int s = 0; s < 64; s++) tgt_tab[s] = '1;
        brd = '0;
        for (int k = 0; k < 16; k++) brd[4*k +: 4] = 4'(8 + (k % 6) + 1);
        run_case(brd, 1'b1, 4'hC, 0, got);
        chk("count_sat", got, 255);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
